// File: rtl/dmac_channel_arbiter.sv
// Two-channel DMAC sequencer/arbiter: grants one channel per transfer, ends on irq, bus error or watchdog.
// Build option: define DMAC_ROUND_ROBIN_EN for round-robin arbitration (default is fixed priority, channel 1 first).
module dmac_channel_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] dma_req,
    input  logic       C_config,
    input  logic       irq,
    input  logic [1:0] M_HResp,
    output logic       channel_en_1,
    output logic       channel_en_2,
    output logic       con_sel,
    output logic       con_en,
    output logic [1:0] dma_ack,
    output logic       dma_err,
    output logic       busy
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ACTIVE,
        DONE,
        ABORT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wdog;
    logic          winner_nxt;

`ifdef DMAC_ROUND_ROBIN_EN
    // 1 = channel 2 served last, so channel 1 wins the first contest after reset
    logic last_served;

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_served <= 1'b1;
        end else if (state == DONE || state == ABORT) begin
            last_served <= con_sel;
        end
    end

    always_comb begin
        winner_nxt = (dma_req == 2'b11) ? ~last_served : dma_req[1];
    end
`else
    always_comb begin
        winner_nxt = ~dma_req[0];
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (C_config && dma_req != 2'b00) begin
                    state_nxt = SELECT;
                end
            end
            SELECT: state_nxt = ACTIVE;
            ACTIVE: begin
                if (M_HResp == 2'b01) begin
                    state_nxt = ABORT;
                end else if (irq) begin
                    state_nxt = DONE;
                end else if (wdog == CNT_LAST) begin
                    state_nxt = ABORT;
                end
            end
            DONE:    state_nxt = IDLE;
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one lines up with the state it describes
    always_ff @(posedge clk) begin
        if (!rst) begin
            channel_en_1 <= 1'b0;
            channel_en_2 <= 1'b0;
            con_sel      <= 1'b0;
            con_en       <= 1'b0;
            dma_ack      <= 2'b00;
            dma_err      <= 1'b0;
            busy         <= 1'b0;
            wdog         <= '0;
        end else begin
            busy         <= (state_nxt != IDLE);
            con_en       <= (state == IDLE) && (state_nxt == SELECT);
            channel_en_1 <= (state_nxt == ACTIVE) && !con_sel;
            channel_en_2 <= (state_nxt == ACTIVE) && con_sel;
            dma_ack      <= (state_nxt == DONE) ? (con_sel ? 2'b10 : 2'b01) : 2'b00;
            dma_err      <= (state_nxt == ABORT);
            if (state == IDLE && state_nxt == SELECT) begin
                con_sel <= winner_nxt;
            end
            if (state == SELECT) begin
                wdog <= '0;
            end else if (state == ACTIVE && wdog != CNT_LAST) begin
                wdog <= wdog + CW'(1);
            end
        end
    end

endmodule

// File: doc/dmac_channel_arbiter.md
# dmac_channel_arbiter

Sequencer and arbiter for the two-channel DMAC datapath. Collects DMA requests from two peripherals and waits for the CPU-written control register to flag a valid configuration. Grants exactly one channel at a time by driving the datapath's channel enables and mux select. Holds the grant until the transfer-complete interrupt, bus error or watchdog expiry, then acknowledges the requester and re-arbitrates.

## Interface
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in cycles for one ACTIVE transfer. Must be ≥2.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `dma_req` input 2: peripheral requests; bit0 → channel 1, bit1 → channel 2. Level-sensitive.
- `C_config` input 1: configuration-valid flag from the datapath control register (bit 16).
- `irq` input 1: transfer-complete from the datapath (OR of the channel interrupts).
- `M_HResp` input 2: master-side AHB response; `2'b01` = ERROR.
- `channel_en_1` output 1: enable to datapath channel 1.
- `channel_en_2` output 1: enable to datapath channel 2.
- `con_sel` output 1: datapath master-mux select; 0 = channel 1, 1 = channel 2.
- `con_en` output 1: one-cycle strobe telling the datapath to latch `con_sel`.
- `dma_ack` output 2: one-cycle completion pulse to the granted requester.
- `dma_err` output 1: one-cycle abort pulse (bus error or timeout).
- `busy` output 1: high in every state except IDLE.

## Operation
- States: IDLE, SELECT, ACTIVE, DONE, ABORT.
- **IDLE.**
  - If `C_config` is high and `dma_req` is nonzero: choose the winner, register `con_sel` = winner, pulse `con_en`, go to SELECT.
  - Otherwise stay in IDLE.
- **SELECT** (1 cycle).
  - Assert `channel_en_x` for the winner only.
  - Clear the watchdog counter.
  - Go to ACTIVE.
- **ACTIVE.**
  - Hold `channel_en_x`. Increment the watchdog counter each cycle.
  - Exit priority, highest first:
    1. `M_HResp`==`2'b01` → ABORT.
    2. `irq` → DONE.
    3. Counter reaches `TIMEOUT_CYCLES-1` → ABORT.
- **DONE** (1 cycle).
  - Deassert both enables.
  - Pulse `dma_ack[winner]`.
  - Record winner as last-served.
  - Go to IDLE.
- **ABORT** (1 cycle).
  - Deassert both enables.
  - Pulse `dma_err`; no `dma_ack`.
  - Record winner as last-served.
  - Go to IDLE.
- **Arbitration.** Fixed priority: channel 1 wins when both request. See Configuration for the alternative.
- **Request sampling.** Requests are sampled only in IDLE. Deassertion of the granted request during ACTIVE is ignored and the transfer runs to completion. A new request during ACTIVE waits.
- **Channel exclusivity.** `channel_en_1` and `channel_en_2` are never high simultaneously.
- **Selection stability.** `con_sel` changes only on the IDLE→SELECT transition.
- **Configuration invalidated.** `C_config` dropping during SELECT or ACTIVE does not cancel the transfer. The datapath clears its control register on `irq`, so `C_config` is normally low on return to IDLE.
- **Watchdog counter.** Width is `$clog2(TIMEOUT_CYCLES)`. It saturates and never wraps.

## Timing
- **Reset.**
  - State returns to IDLE.
  - All outputs 0: `channel_en_1`, `channel_en_2`, `con_sel`, `con_en`, `dma_ack`, `dma_err`, `busy`.
  - Last-served is set to channel 2, so channel 1 wins the first round-robin contest.
  - Reset mid-transfer drops enables on the next edge. No ack or err is issued.
- **All outputs registered.**
- **Request to enable latency.** `dma_req` and `C_config` sampled high at edge N gives:
  - `con_en` = 1 and `con_sel` valid during cycle N+1;
  - `channel_en_x` high from edge N+2.
- **Completion.** `irq` sampled at edge M gives enables low and `dma_ack` pulse from edge M+1, for exactly one cycle.
- **Minimum spacing.** Earliest re-grant is `con_en` at M+2, so grants are at least 4 cycles apart.
- **Simultaneous events.** `irq` and ERROR on the same cycle resolve as ABORT.
- **Timeout.** The abort occurs exactly `TIMEOUT_CYCLES` cycles after entering ACTIVE.

## Configuration
- **Macro:** `DMAC_ROUND_ROBIN_EN`.
- **Defined:** round-robin arbitration. When both channels request, the channel not recorded as last-served wins. A single requester always wins.
- **Undefined:** fixed priority, channel 1 over channel 2. Last-served register is absent.

## Test plan
- **Single request.** `C_config`=1, `dma_req`=2'b01 at cycle 0.
  - Required: `con_en`=1, `con_sel`=0 at cycle 1; `channel_en_1`=1 from cycle 2.
  - Then `irq` at cycle 10 → `dma_ack`=2'b01 for one cycle at cycle 11, enables 0, `busy`=0 at cycle 12.
- **Contention, fixed priority.** `dma_req`=2'b11 held through three transfers.
  - Required: every grant is to channel 1; `channel_en_2` is never asserted.
- **Contention, `DMAC_ROUND_ROBIN_EN`.** Same stimulus as the previous test.
  - Required: grants alternate ch1, ch2, ch1; `con_sel` sequence is 0, 1, 0.
- **Bus error.** `M_HResp`=2'b01 in ACTIVE on channel 2.
  - Required: next cycle `dma_err`=1, both enables 0, `dma_ack`=0; then IDLE.
  - Also drive `irq` and ERROR on the same cycle → ABORT.
- **Timeout.** `TIMEOUT_CYCLES`=16, no `irq`.
  - Required: `dma_err` pulses 16 cycles after ACTIVE entry.
- **Reset mid-ACTIVE.** `rst`=0 for one edge.
  - Required: all outputs 0 next cycle, no ack.
  - Also: `C_config`=0 with `dma_req`=2'b01 → no grant, `busy` stays 0.
